// File: rtl/wash_pkg.sv
// Shared state codes, output bundle and helpers for the wash-programme controller.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package wash_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'd0,
        ST_DELAY = 4'd1,
        ST_FILL  = 4'd2,
        ST_HEAT  = 4'd3,
        ST_DET   = 4'd4,
        ST_WASH  = 4'd5,
        ST_RINSE = 4'd6,
        ST_SPIN  = 4'd7,
        ST_DONE  = 4'd8,
        ST_FAULT = 4'd9
    } state_t;

    // Registered output bundle of the controller.
    typedef struct packed {
        logic door_lock;
        logic water_in;
        logic heater;
        logic detergent;
        logic wash;
        logic rinse;
        logic spin;
        logic busy;
        logic done;
        logic fault;
    } out_t;

    // True for the states that make up a running programme (DELAY..SPIN).
    function automatic logic is_active(input state_t s);
        return (s >= ST_DELAY) && (s <= ST_SPIN);
    endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Up-counter with clear, enable and terminal compare; WRAP=1 makes it a free-running prescaler.
// Latency: at_term is combinational from the registered count; count updates one clk after en.
// Backpressure: en low freezes the count; clr has priority over en.
// Ports: clk/reset (async, active-high), clr, en, term (terminal value), at_term (cnt==term).
module wash_phase_timer #(
    parameter int CNT_W = 8,
    parameter bit WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_term = (cnt_q == term);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (WRAP && at_term) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Wash-programme sequencer: delay, fill, heat, detergent, wash, rinse passes, spin; door fault handling.
// Latency: a start edge or phase expiry sampled on one clk edge shows as the new state on the next cycle.
// Backpressure: pause or power loss sampled on an edge freezes the following cycle (counters, state, actuators off).
// Ports: clk, reset (async, active-high); start/pause/power_ok/door_closed controls; cold, rinses,
//        delay_min programme selection; state code, actuator enables, door_lock, rinse_pass, busy/done/fault.
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int DELAY_W       = 3,
    parameter int TICKS_PER_MIN = 60,
    parameter int CNT_W         = 8,
    parameter int T_FILL        = 2,
    parameter int T_HEAT        = 9,
    parameter int T_DET         = 2,
    parameter int T_WASH        = 6,
    parameter int T_RINSE       = 6,
    parameter int T_SPIN        = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               power_ok,
    input  logic               door_closed,
    input  logic               cold,
    input  logic [1:0]         rinses,
    input  logic [DELAY_W-1:0] delay_min,
    output logic [STATE_W-1:0] state,
    output logic               door_lock,
    output logic               water_in,
    output logic               heater,
    output logic               detergent,
    output logic               wash,
    output logic               rinse,
    output logic               spin,
    output logic [1:0]         rinse_pass,
    output logic               busy,
    output logic               done,
    output logic               fault
);

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic               hold_q, hold_d;      // current cycle is frozen (pause or power loss)
    logic               cold_q, cold_d;
    logic [1:0]         rinses_q, rinses_d;
    logic [DELAY_W-1:0] min_q, min_d;        // delay minutes still to run
    logic [1:0]         pass_q, pass_d;
    out_t               out_q, out_d;

    logic               start_edge, running, ph_en, pre_en, ph_done, min_tick, rinse_adv, act;
    logic               ph_at_term, pre_at_term;
    logic [CNT_W-1:0]   ph_term;

    assign start_edge = start & ~start_q;
    // A cycle counts only if the programme is running and the previous edge did not freeze it.
    assign running    = is_active(state_q) & ~hold_q;
    assign ph_en      = running & (state_q != ST_DELAY);
    assign pre_en     = running & (state_q == ST_DELAY);
    assign ph_done    = ph_en & ph_at_term;
    assign min_tick   = pre_en & pre_at_term;

    always_comb begin
        ph_term = '0;
        case (state_q)
            ST_FILL:  ph_term = CNT_W'(T_FILL - 1);
            ST_HEAT:  ph_term = CNT_W'(T_HEAT - 1);
            ST_DET:   ph_term = CNT_W'(T_DET - 1);
            ST_WASH:  ph_term = CNT_W'(T_WASH - 1);
            ST_RINSE: ph_term = CNT_W'(T_RINSE - 1);
            ST_SPIN:  ph_term = CNT_W'(T_SPIN - 1);
            default:  ph_term = '0;
        endcase
    end

    wash_phase_timer #(.CNT_W(CNT_W), .WRAP(1'b0)) u_phase_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     ((state_d != state_q) | rinse_adv),
        .en      (ph_en),
        .term    (ph_term),
        .at_term (ph_at_term)
    );

    wash_phase_timer #(.CNT_W(CNT_W), .WRAP(1'b1)) u_min_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_d != state_q),
        .en      (pre_en),
        .term    (CNT_W'(TICKS_PER_MIN - 1)),
        .at_term (pre_at_term)
    );

    always_comb begin
        state_d   = state_q;
        start_d   = start;
        cold_d    = cold_q;
        rinses_d  = rinses_q;
        min_d     = min_q;
        pass_d    = pass_q;
        rinse_adv = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (power_ok && start_edge && door_closed) begin
                    cold_d   = cold;
                    rinses_d = (rinses == 2'd0) ? 2'd1 : rinses;
                    min_d    = delay_min;
                    state_d  = (delay_min != '0) ? ST_DELAY : ST_FILL;
                end
            end
            ST_DELAY: begin
                if (min_tick) begin
                    min_d = min_q - DELAY_W'(1);
                    if (min_q == DELAY_W'(1)) state_d = ST_FILL;
                end
            end
            ST_FILL:  if (ph_done) state_d = cold_q ? ST_DET : ST_HEAT;
            ST_HEAT:  if (ph_done) state_d = ST_DET;
            ST_DET:   if (ph_done) state_d = ST_WASH;
            ST_WASH: begin
                if (ph_done) begin
                    state_d = ST_RINSE;
                    pass_d  = 2'd1;
                end
            end
            ST_RINSE: begin
                // Stay in RINSE across pass boundaries; the phase counter restarts per pass.
                if (ph_done) begin
                    if (pass_q == rinses_q) begin
                        state_d = ST_SPIN;
                    end else begin
                        pass_d    = pass_q + 2'd1;
                        rinse_adv = 1'b1;
                    end
                end
            end
            ST_SPIN:  if (ph_done) state_d = ST_DONE;
            ST_DONE:  if (power_ok && !door_closed) state_d = ST_IDLE;
            default:  ;
        endcase

        // Door opening beats any phase expiry in the same cycle, paused or not.
        if (is_active(state_q) && power_ok && !door_closed) state_d = ST_FAULT;
        if (state_d != ST_RINSE) pass_d = 2'd0;

        hold_d = ~power_ok | (pause & is_active(state_d));
    end

    always_comb begin
        act             = is_active(state_d) & ~hold_d;
        out_d           = '0;
        out_d.water_in  = act && (state_d == ST_FILL);
        out_d.heater    = act && (state_d == ST_HEAT);
        out_d.detergent = act && (state_d == ST_DET);
        out_d.wash      = act && (state_d == ST_WASH);
        out_d.rinse     = act && (state_d == ST_RINSE);
        out_d.spin      = act && (state_d == ST_SPIN);
        out_d.busy      = is_active(state_d);
        out_d.done      = (state_d == ST_DONE);
        out_d.fault     = (state_d == ST_FAULT);
        // Without supply the lock keeps whatever it was doing when power went.
        out_d.door_lock = power_ok ? (is_active(state_d) || (state_d == ST_FAULT)) : out_q.door_lock;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            hold_q   <= 1'b0;
            cold_q   <= 1'b0;
            rinses_q <= 2'd0;
            min_q    <= '0;
            pass_q   <= 2'd0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            hold_q   <= hold_d;
            cold_q   <= cold_d;
            rinses_q <= rinses_d;
            min_q    <= min_d;
            pass_q   <= pass_d;
            out_q    <= out_d;
        end
    end

    assign state      = state_q;
    assign rinse_pass = pass_q;
    assign door_lock  = out_q.door_lock;
    assign water_in   = out_q.water_in;
    assign heater     = out_q.heater;
    assign detergent  = out_q.detergent;
    assign wash       = out_q.wash;
    assign rinse      = out_q.rinse;
    assign spin       = out_q.spin;
    assign busy       = out_q.busy;
    assign done       = out_q.done;
    assign fault      = out_q.fault;

endmodule
